sram_arbiter: RTL and testbench
===============================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 19, SRAM controller byte-address width.
REQ-002 Parameter DATA_W, default 8, byte data width.
REQ-003 Parameter ACCESS_CYCLES, default 3, controller access length in clocks after trigger; legal range 1..15.
REQ-004 Parameter MAX_CONSEC, default 4, max consecutive port-0 grants while port 1 waits; legal range 1..15.
REQ-005 clk  in  1  system clock, rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 req0  in  1  port 0 (video fetch, high priority) request, level.
REQ-008 rw0  in  1  port 0 direction: 1 = read, 0 = write.
REQ-009 addr0  in  ADDR_W  port 0 byte address.
REQ-010 wdata0  in  DATA_W  port 0 write byte.
REQ-011 ack0  out  1  port 0 completion, one-cycle pulse.
REQ-012 req1, rw1, addr1, wdata1, ack1: port 1 (host/writer, low priority), same widths and meanings as port 0.
REQ-013 rdata  out  DATA_W  read byte, shared, valid only in the cycle ack0 or ack1 is high.
REQ-014 busy  out  1  high whenever the state is not IDLE.
REQ-015 mem_trig  out  1  one-cycle trigger to the SRAM controller.
REQ-016 mem_rw, mem_addr, mem_wdata  out  1/ADDR_W/DATA_W  command to the controller, registered.
REQ-017 mem_rdata  in  DATA_W  controller read byte.

Function
REQ-018 The FSM SHALL have the states IDLE, ISSUE, WAIT and DONE.
REQ-019 In IDLE, if any req is high, the block SHALL choose a winner, latch its rw/addr/wdata onto mem_rw/mem_addr/mem_wdata and go to ISSUE; otherwise it SHALL stay in IDLE.
REQ-020 In ISSUE, mem_trig SHALL be 1 for exactly one cycle, the down-counter SHALL load ACCESS_CYCLES-1, and the FSM SHALL go to WAIT.
REQ-021 In WAIT, the counter SHALL decrement each cycle; when it is 0, the block SHALL register mem_rdata into rdata (reads only; rdata holds its value for writes) and go to DONE.
REQ-022 In DONE, the winner's ack SHALL be 1 for one cycle, then the FSM SHALL return to IDLE.
REQ-023 Latency SHALL be ACCESS_CYCLES+2 clocks from the IDLE sampling edge to ack (5 at default).
REQ-024 Requesters SHALL hold req, rw, addr and wdata stable until ack; req still high in the cycle after ack counts as a new request.
REQ-025 mem_rw, mem_addr and mem_wdata SHALL remain stable from ISSUE through DONE.
REQ-026 Port 0 SHALL win when both ports request, unless the consecutive-grant counter equals MAX_CONSEC, in which case port 1 SHALL win.
REQ-027 The consecutive-grant counter SHALL increment on a port-0 grant with req1 high, clear on a port-1 grant or whenever req1 is low in IDLE, and saturate at MAX_CONSEC.
REQ-028 Requests arriving outside IDLE SHALL be ignored until the next IDLE sampling; no request SHALL be dropped while its req is held.
REQ-029 ack0 and ack1 SHALL never be high in the same cycle, and at most one transaction SHALL be outstanding.

Reset
REQ-030 On rst low, the FSM SHALL go to IDLE asynchronously.
REQ-031 On rst low, these SHALL be 0: mem_trig, mem_addr, mem_wdata, rdata, ack0, ack1, busy, both counters.
REQ-032 On rst low, mem_rw SHALL be 1 (read, safe).
REQ-033 Reset mid-transaction SHALL abort it with no ack; the requester re-arbitrates after reset release.

Structure
REQ-034 Package sram_arb_pkg SHALL hold the state enum, the default parameter constants and the read/write encoding constants.
REQ-035 Winner selection and the starvation counter SHALL be one sub-module, sram_arb_prio; everything else stays in sram_arbiter.

Verification
REQ-036 Single read: req0=1, rw0=1, addr0=0x00010, mem_rdata=0xA5 -> one mem_trig, ack0 five cycles later, rdata=0xA5.
REQ-037 Single write: req1=1, rw1=0, addr1=0x40003, wdata1=0x3C -> mem_addr=0x40003, mem_wdata=0x3C, mem_rw=0, ack1 at cycle 5, rdata unchanged.
REQ-038 Contention: req0 and req1 held high continuously -> grant order 0,0,0,0,1,0,0,0,0,1 with default MAX_CONSEC.
REQ-039 Simultaneous single requests: req0 and req1 rise together -> port 0 served first, port 1 acked 5 cycles later; never both acks in one cycle.
REQ-040 Reset abort: rst low in the 2nd WAIT cycle -> outputs at reset values immediately, no ack; after release with req still high, full transaction and ack.
REQ-041 ACCESS_CYCLES=1 build: single read -> ack exactly 3 cycles after sampling.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-port SRAM arbiter: FSM states,
// default build parameters and the controller read/write encoding.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int DEF_ADDR_W        = 19;
  localparam int DEF_DATA_W        = 8;
  localparam int DEF_ACCESS_CYCLES = 3;
  localparam int DEF_MAX_CONSEC    = 4;

  // Both counters top out at 15, so four bits cover every legal build.
  localparam int CNT_W = 4;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/sram_arb_prio.sv
// Fixed-priority winner selection (port 0 first) with a starvation counter
// that hands the next grant to port 1 after MAX_CONSEC back-to-back port-0 wins.
module sram_arb_prio
  import sram_arb_pkg::*;
#(
  parameter int MAX_CONSEC = DEF_MAX_CONSEC
) (
  input  logic clk,
  input  logic rst,
  input  logic sample_i,
  input  logic req0_i,
  input  logic req1_i,
  output logic any_req_o,
  output logic grant1_o
);

  localparam logic [CNT_W-1:0] MAX_C   = CNT_W'(MAX_CONSEC);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] consec_q;
  logic [CNT_W-1:0] consec_d;

  // Winner decode from the live request lines and the starvation count.
  always_comb begin
    any_req_o = req0_i | req1_i;
    grant1_o  = req1_i & (~req0_i | (consec_q == MAX_C));
  end

  // Count only port-0 wins that made port 1 wait; any other IDLE outcome clears.
  always_comb begin
    consec_d = consec_q;
    if (sample_i) begin
      if (!req1_i) begin
        consec_d = '0;
      end else if (grant1_o) begin
        consec_d = '0;
      end else if (consec_q != MAX_C) begin
        consec_d = consec_q + CNT_ONE;
      end else begin
        consec_d = consec_q;
      end
    end else begin
      consec_d = consec_q;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      consec_q <= '0;
    end else begin
      consec_q <= consec_d;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Two-port SRAM arbiter: picks one requester in IDLE, fires a single
// controller trigger, waits out the access time and acks the winner.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W        = DEF_ADDR_W,
  parameter int DATA_W        = DEF_DATA_W,
  parameter int ACCESS_CYCLES = DEF_ACCESS_CYCLES,
  parameter int MAX_CONSEC    = DEF_MAX_CONSEC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              rw0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  input  logic              req1,
  input  logic              rw1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              mem_trig,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              win1_q, win1_d;
  logic              mem_trig_q, mem_trig_d;
  logic              mem_rw_q, mem_rw_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic              busy_q, busy_d;
  logic              any_req_s;
  logic              grant1_s;
  logic              sample_s;

  assign sample_s = (state_q == ST_IDLE);

  sram_arb_prio #(
    .MAX_CONSEC (MAX_CONSEC)
  ) u_prio (
    .clk       (clk),
    .rst       (rst),
    .sample_i  (sample_s),
    .req0_i    (req0),
    .req1_i    (req1),
    .any_req_o (any_req_s),
    .grant1_o  (grant1_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  state_d = any_req_s ? ST_ISSUE : ST_IDLE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  state_d = (cnt_q == '0) ? ST_DONE : ST_WAIT;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output and datapath next values; strobes are decoded from the next state
  // so they appear registered in the same cycle as the state they belong to.
  always_comb begin
    cnt_d       = cnt_q;
    win1_d      = win1_q;
    mem_rw_d    = mem_rw_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    mem_trig_d  = (state_d == ST_ISSUE);
    busy_d      = (state_d != ST_IDLE);
    ack0_d      = (state_d == ST_DONE) & ~win1_q;
    ack1_d      = (state_d == ST_DONE) & win1_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req_s) begin
          win1_d      = grant1_s;
          mem_rw_d    = grant1_s ? rw1 : rw0;
          mem_addr_d  = grant1_s ? addr1 : addr0;
          mem_wdata_d = grant1_s ? wdata1 : wdata0;
        end else begin
          win1_d = win1_q;
        end
      end
      ST_ISSUE: cnt_d = CNT_LOAD;
      ST_WAIT: begin
        if (cnt_q == '0) begin
          rdata_d = (mem_rw_q == RW_READ) ? mem_rdata : rdata_q;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_DONE: cnt_d = cnt_q;
      default: cnt_d = '0;
    endcase
  end

  // Datapath and output registers; a reset aborts any access without an ack.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q       <= '0;
      win1_q      <= 1'b0;
      mem_trig_q  <= 1'b0;
      mem_rw_q    <= RW_READ;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      win1_q      <= win1_d;
      mem_trig_q  <= mem_trig_d;
      mem_rw_q    <= mem_rw_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      busy_q      <= busy_d;
    end
  end

  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign rdata     = rdata_q;
  assign busy      = busy_q;
  assign mem_trig  = mem_trig_q;
  assign mem_rw    = mem_rw_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed cases plus randomized
// requests checked against a transaction-level arbitration model.
module tb_sram_arbiter;

  localparam int AW = 19;
  localparam int DW = 8;
  localparam int AC = 3;
  localparam int MC = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, rw0, req1, rw1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          ack0, ack1, busy, mem_trig, mem_rw;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata, rdata;

  logic          b_req0, b_rw0, b_req1, b_rw1;
  logic [AW-1:0] b_addr0, b_addr1;
  logic [DW-1:0] b_wdata0, b_wdata1;
  logic          b_ack0, b_ack1, b_busy, b_mem_trig, b_mem_rw;
  logic [AW-1:0] b_mem_addr;
  logic [DW-1:0] b_mem_wdata, b_mem_rdata, b_rdata;

  int checks = 0;
  int failures = 0;

  // Reference model state: starvation count, expected rdata, pending requests.
  int            consec = 0;
  logic [DW-1:0] exp_rdata = 8'h00;
  bit            pend0 = 1'b0, pend1 = 1'b0;
  logic          f_rw0, f_rw1;
  logic [AW-1:0] f_a0, f_a1;
  logic [DW-1:0] f_w0, f_w1;

  sram_arbiter u_dut (
    .clk(clk), .rst(rst),
    .req0(req0), .rw0(rw0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0),
    .req1(req1), .rw1(rw1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1),
    .rdata(rdata), .busy(busy), .mem_trig(mem_trig), .mem_rw(mem_rw),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  sram_arbiter #(.ACCESS_CYCLES(1)) u_dut_ac1 (
    .clk(clk), .rst(rst),
    .req0(b_req0), .rw0(b_rw0), .addr0(b_addr0), .wdata0(b_wdata0), .ack0(b_ack0),
    .req1(b_req1), .rw1(b_rw1), .addr1(b_addr1), .wdata1(b_wdata1), .ack1(b_ack1),
    .rdata(b_rdata), .busy(b_busy), .mem_trig(b_mem_trig), .mem_rw(b_mem_rw),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic new_req(input int p, input logic rw, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    if (p == 0) begin
      pend0 = 1'b1; f_rw0 = rw; f_a0 = a; f_w0 = d;
    end else begin
      pend1 = 1'b1; f_rw1 = rw; f_a1 = a; f_w1 = d;
    end
  endtask

  task automatic idle_cycles(input int n);
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (n) tick;
    consec = 0;
    chk("idle_quiet", 32'({busy, mem_trig, ack0, ack1}), 32'h0);
  endtask

  // One arbitration round starting in IDLE; returns the port the DUT acked.
  task automatic round(input logic [DW-1:0] rd, output int ow);
    int            win, cyc;
    bit            got;
    logic          erw;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    mem_rdata = rd;
    req0 = pend0; rw0 = f_rw0; addr0 = f_a0; wdata0 = f_w0;
    req1 = pend1; rw1 = f_rw1; addr1 = f_a1; wdata1 = f_w1;
    chk("idle_busy", 32'(busy), 32'h0);
    win = (pend1 && (!pend0 || consec == MC)) ? 1 : 0;
    if (!pend1 || win == 1) consec = 0;
    else if (consec < MC) consec++;
    erw = (win == 1) ? f_rw1 : f_rw0;
    ea  = (win == 1) ? f_a1 : f_a0;
    ed  = (win == 1) ? f_w1 : f_w0;
    tick;
    chk("issue_trig", 32'(mem_trig), 32'h1);
    chk("issue_busy", 32'(busy), 32'h1);
    chk("cmd_rw", 32'(mem_rw), 32'(erw));
    chk("cmd_addr", 32'(mem_addr), 32'(ea));
    chk("cmd_wdata", 32'(mem_wdata), 32'(ed));
    cyc = 1;
    got = 1'b0;
    while (!got && cyc < 40) begin
      tick;
      cyc++;
      chk("ack_excl", 32'(ack0 & ack1), 32'h0);
      chk("trig_once", 32'(mem_trig), 32'h0);
      chk("cmd_stable", 32'({mem_rw, mem_addr, mem_wdata}), 32'({erw, ea, ed}));
      got = ack0 | ack1;
    end
    chk("ack_seen", 32'(got), 32'h1);
    chk("latency", cyc, AC + 2);
    ow = ack1 ? 1 : 0;
    chk("winner", ow, win);
    if (erw == 1'b1) exp_rdata = rd;
    chk("rdata", 32'(rdata), 32'(exp_rdata));
    if (win == 1) begin
      pend1 = 1'b0; req1 = 1'b0;
    end else begin
      pend0 = 1'b0; req0 = 1'b0;
    end
    tick;
    chk("post_idle", 32'({busy, ack0, ack1}), 32'h0);
  endtask

  initial begin
    int ow;
    int cyc;
    bit bgot;
    int exp_seq[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

    rst = 1'b0;
    req0 = 1'b0; rw0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; rw1 = 1'b0; addr1 = '0; wdata1 = '0;
    mem_rdata = '0;
    b_req0 = 1'b0; b_rw0 = 1'b0; b_addr0 = '0; b_wdata0 = '0;
    b_req1 = 1'b0; b_rw1 = 1'b0; b_addr1 = '0; b_wdata1 = '0;
    b_mem_rdata = '0;
    f_rw0 = 1'b0; f_rw1 = 1'b0; f_a0 = '0; f_a1 = '0; f_w0 = '0; f_w1 = '0;
    tick;
    tick;
    chk("rst_zero", 32'({mem_trig, ack0, ack1, busy}), 32'h0);
    chk("rst_addr", 32'(mem_addr), 32'h0);
    chk("rst_data", 32'({mem_wdata, rdata}), 32'h0);
    chk("rst_rw", 32'(mem_rw), 32'h1);
    chk("rst_rw_ac1", 32'(b_mem_rw), 32'h1);
    rst = 1'b1;
    tick;

    // Single read, then single write that must leave rdata alone.
    new_req(0, 1'b1, 19'h00010, 8'h00);
    round(8'hA5, ow);
    chk("read_port", ow, 0);
    chk("read_rdata", 32'(rdata), 32'hA5);
    new_req(1, 1'b0, 19'h40003, 8'h3C);
    round(8'h77, ow);
    chk("write_port", ow, 1);
    chk("write_rdata_hold", 32'(rdata), 32'hA5);

    // Simultaneous single requests.
    new_req(0, 1'b1, 19'h00123, 8'h11);
    new_req(1, 1'b0, 19'h7FFFF, 8'h22);
    round(8'h5C, ow);
    chk("simul_first", ow, 0);
    round(8'h6D, ow);
    chk("simul_second", ow, 1);

    // Both ports held continuously.
    idle_cycles(1);
    new_req(0, 1'($urandom), 19'($urandom), 8'($urandom));
    new_req(1, 1'($urandom), 19'($urandom), 8'($urandom));
    for (int i = 0; i < 10; i++) begin
      round(8'($urandom), ow);
      chk("contention_order", ow, exp_seq[i]);
      new_req(ow, 1'($urandom), 19'($urandom), 8'($urandom));
    end
    for (int i = 0; i < 4 && (pend0 || pend1); i++) round(8'($urandom), ow);

    // Randomized traffic against the model.
    for (int i = 0; i < 60; i++) begin
      if (!pend0 && $urandom_range(0, 2) != 0)
        new_req(0, 1'($urandom), 19'($urandom), 8'($urandom));
      if (!pend1 && $urandom_range(0, 2) != 0)
        new_req(1, 1'($urandom), 19'($urandom), 8'($urandom));
      if (!pend0 && !pend1) idle_cycles(1);
      else round(8'($urandom), ow);
    end
    for (int i = 0; i < 4 && (pend0 || pend1); i++) round(8'($urandom), ow);

    // Reset in the second WAIT cycle aborts the access; the held request retries.
    new_req(0, 1'b1, 19'h01234, 8'h00);
    mem_rdata = 8'hC3;
    req0 = 1'b1; rw0 = f_rw0; addr0 = f_a0; wdata0 = f_w0;
    tick;
    tick;
    tick;
    rst = 1'b0;
    #1;
    chk("abort_zero", 32'({mem_trig, ack0, ack1, busy}), 32'h0);
    chk("abort_cmd", 32'({mem_addr, mem_wdata}), 32'h0);
    chk("abort_rdata", 32'(rdata), 32'h0);
    chk("abort_rw", 32'(mem_rw), 32'h1);
    repeat (3) begin
      tick;
      chk("abort_no_ack", 32'({ack0, ack1}), 32'h0);
    end
    rst = 1'b1;
    consec = 0;
    exp_rdata = 8'h00;
    round(8'hC3, ow);
    chk("abort_retry_port", ow, 0);

    // ACCESS_CYCLES=1 build: ack three cycles after sampling.
    b_req0 = 1'b1; b_rw0 = 1'b1; b_addr0 = 19'h0ABCD; b_mem_rdata = 8'h5A;
    tick;
    chk("ac1_trig", 32'(b_mem_trig), 32'h1);
    cyc = 1;
    bgot = 1'b0;
    while (!bgot && cyc < 20) begin
      tick;
      cyc++;
      bgot = b_ack0;
    end
    chk("ac1_latency", cyc, 3);
    chk("ac1_rdata", 32'(b_rdata), 32'h5A);
    chk("ac1_addr", 32'(b_mem_addr), 32'h0ABCD);
    b_req0 = 1'b0;
    tick;
    chk("ac1_ack_pulse", 32'({b_ack0, b_ack1}), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
